branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 162 ++++++++++++++++
 tb/tb_branch_resolve.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch resolve unit: evaluates the branch condition for a resolving
// branch, trains a PC-indexed table of 2-bit saturating direction
// counters, reports the resolved direction and misprediction one cycle
// later, and keeps a saturating count of mispredictions. A separate
// lookup port returns the predicted direction for the fetch PC.
module branch_resolve #(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 16,
    parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] lk_pc,
    output logic             lk_taken,
    input  logic             rs_valid,
    input  logic [WIDTH-1:0] rs_pc,
    input  logic [WIDTH-1:0] rs_a,
    input  logic [WIDTH-1:0] rs_b,
    input  logic [2:0]       rs_func,
    input  logic             rs_pred,
    input  logic             flush,
    output logic             out_valid,
    output logic             out_taken,
    output logic             out_mispred,
    output logic [15:0]      mispred_cnt
);

    // Condition codes on rs_func.
    localparam logic [2:0] FUNC_BEQ  = 3'b000;
    localparam logic [2:0] FUNC_BNE  = 3'b001;
    localparam logic [2:0] FUNC_BLEZ = 3'b010;
    localparam logic [2:0] FUNC_BGTZ = 3'b011;
    localparam logic [2:0] FUNC_BLTZ = 3'b100;
    localparam logic [2:0] FUNC_BGEZ = 3'b101;
    localparam logic [2:0] FUNC_ALW  = 3'b110;
    localparam logic [2:0] FUNC_NEV  = 3'b111;

    // Counter value every entry starts from: weakly not-taken.
    localparam logic [1:0] CNT_INIT = 2'b01;

    // Evaluate the branch condition. Sign comes from the MSB of A and the
    // zero test spans all of A; B only matters for the equality codes.
    function automatic logic eval_cond(input logic [2:0]       func,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
        logic neg;
        logic zero;
        logic res;
        neg  = a[WIDTH-1];
        zero = (a == {WIDTH{1'b0}});
        case (func)
            FUNC_BEQ:  res = (a == b);
            FUNC_BNE:  res = (a != b);
            FUNC_BLEZ: res = neg | zero;
            FUNC_BGTZ: res = ~neg & ~zero;
            FUNC_BLTZ: res = neg;
            FUNC_BGEZ: res = ~neg;
            FUNC_ALW:  res = 1'b1;
            FUNC_NEV:  res = 1'b0;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

    // Next value of a 2-bit saturating direction counter.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt,
                                              input logic       taken);
        logic [1:0] nxt;
        if (taken) begin
            if (cnt == 2'b11) begin
                nxt = 2'b11;
            end else begin
                nxt = cnt + 2'b01;
            end
        end else begin
            if (cnt == 2'b00) begin
                nxt = 2'b00;
            end else begin
                nxt = cnt - 2'b01;
            end
        end
        return nxt;
    endfunction

    logic [1:0]       bht_r [BHT_DEPTH];
    logic [IDX_W-1:0] lk_idx_s;
    logic [IDX_W-1:0] rs_idx_s;
    logic             accept_s;
    logic             taken_s;
    logic             mispred_s;
    logic             out_valid_r;
    logic             out_taken_r;
    logic             out_mispred_r;
    logic [15:0]      mispred_cnt_r;
    logic             unused_s;

    // Word-aligned PCs: the two low bits never select an entry.
    assign lk_idx_s = lk_pc[IDX_W+1:2];
    assign rs_idx_s = rs_pc[IDX_W+1:2];

    // PC bits outside the index field are intentionally ignored.
    assign unused_s = ^{lk_pc, rs_pc};

    // Decode the resolve request: acceptance, direction, misprediction.
    always_comb begin
        accept_s  = 1'b0;
        taken_s   = 1'b0;
        mispred_s = 1'b0;
        if (rs_valid && !flush) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        taken_s   = eval_cond(rs_func, rs_a, rs_b);
        mispred_s = taken_s ^ rs_pred;
    end

    // Prediction lookup reads the table as it stands before this edge's
    // update, so a same-index update shows up only from the next cycle.
    assign lk_taken = bht_r[lk_idx_s][1];

    // Train the direction table on every accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_r[i] <= CNT_INIT;
            end
        end else if (accept_s) begin
            bht_r[rs_idx_s] <= sat_update(bht_r[rs_idx_s], taken_s);
        end
    end

    // Register the result; direction and mispredict hold while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_taken_r   <= 1'b0;
            out_mispred_r <= 1'b0;
        end else begin
            out_valid_r <= accept_s;
            if (accept_s) begin
                out_taken_r   <= taken_s;
                out_mispred_r <= mispred_s;
            end
        end
    end

    // Count accepted mispredictions, sticking at the top value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispred_cnt_r <= 16'h0000;
        end else if (accept_s && mispred_s && (mispred_cnt_r != 16'hFFFF)) begin
            mispred_cnt_r <= mispred_cnt_r + 16'h0001;
        end
    end

    assign out_valid   = out_valid_r;
    assign out_taken   = out_taken_r;
    assign out_mispred = out_mispred_r;
    assign mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve.
module tb_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic [31:0] lk_pc;
    logic        lk_taken;
    logic        rs_valid;
    logic [31:0] rs_pc;
    logic [31:0] rs_a;
    logic [31:0] rs_b;
    logic [2:0]  rs_func;
    logic        rs_pred;
    logic        flush;
    logic        out_valid;
    logic        out_taken;
    logic        out_mispred;
    logic [15:0] mispred_cnt;

    int          n_checks;
    int          n_errors;
    logic [15:0] exp_cnt;

    branch_resolve #(.WIDTH(32), .BHT_DEPTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lk_pc       (lk_pc),
        .lk_taken    (lk_taken),
        .rs_valid    (rs_valid),
        .rs_pc       (rs_pc),
        .rs_a        (rs_a),
        .rs_b        (rs_b),
        .rs_func     (rs_func),
        .rs_pred     (rs_pred),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_taken   (out_taken),
        .out_mispred (out_mispred),
        .mispred_cnt (mispred_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request, let it be clocked, then check the result.
    task automatic resolve(input string tag, input logic [31:0] pc, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] func, input logic pred,
                           input logic fl, input logic exp_taken);
        rs_valid = 1'b1;
        rs_pc    = pc;
        rs_a     = a;
        rs_b     = b;
        rs_func  = func;
        rs_pred  = pred;
        flush    = fl;
        @(posedge clk);
        #1;
        if (!fl && (exp_taken != pred) && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'h0001;
        if (fl) begin
            check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        end else begin
            check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, ".taken"}, {31'd0, out_taken}, {31'd0, exp_taken});
            check({tag, ".mispred"}, {31'd0, out_mispred}, {31'd0, exp_taken ^ pred});
        end
        check({tag, ".cnt"}, {16'd0, mispred_cnt}, {16'd0, exp_cnt});
    endtask

    task automatic idle();
        rs_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse launched between clock edges.
    task automatic do_reset(input string tag);
        rs_valid = 1'b0;
        flush    = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        exp_cnt = 16'h0000;
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".cnt"}, {16'd0, mispred_cnt}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  tbl_eq  [3];
    logic [7:0]  tbl_ne  [3];
    logic [31:0] tbl_a   [3];
    logic [7:0]  row;

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = 16'h0000;
        rst_n    = 1'b0;
        lk_pc    = 32'h0040_0000;
        rs_valid = 1'b0;
        rs_pc    = 32'h0;
        rs_a     = 32'h0;
        rs_b     = 32'h0;
        rs_func  = 3'b000;
        rs_pred  = 1'b0;
        flush    = 1'b0;

        // Reset state, with a request held during reset that must be dropped.
        #2;
        check("rst.lk_taken", {31'd0, lk_taken}, 32'd0);
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.taken", {31'd0, out_taken}, 32'd0);
        check("rst.mispred", {31'd0, out_mispred}, 32'd0);
        check("rst.cnt", {16'd0, mispred_cnt}, 32'd0);
        rs_valid = 1'b1;
        rs_func  = 3'b110;
        @(posedge clk);
        #1;
        check("rst_req.valid", {31'd0, out_valid}, 32'd0);
        check("rst_req.cnt", {16'd0, mispred_cnt}, 32'd0);
        rs_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req.lk", {31'd0, lk_taken}, 32'd0);

        // Condition table, bit k = expected direction for func k.
        tbl_a[0] = 32'h8000_0000; tbl_eq[0] = 8'h55; tbl_ne[0] = 8'h56;
        tbl_a[1] = 32'h0000_0000; tbl_eq[1] = 8'h65; tbl_ne[1] = 8'h66;
        tbl_a[2] = 32'h0000_0001; tbl_eq[2] = 8'h69; tbl_ne[2] = 8'h6A;
        for (int i = 0; i < 3; i++) begin
            for (int f = 0; f < 8; f++) begin
                row = tbl_eq[i];
                resolve($sformatf("cond_eq_a%0d_f%0d", i, f), 32'h0040_0100, tbl_a[i], tbl_a[i],
                        3'(f), row[f], 1'b0, row[f]);
                row = tbl_ne[i];
                resolve($sformatf("cond_ne_a%0d_f%0d", i, f), 32'h0040_0100, tbl_a[i], tbl_a[i] ^ 32'h1,
                        3'(f), ~row[f], 1'b0, row[f]);
            end
        end
        idle();
        check("idle.valid", {31'd0, out_valid}, 32'd0);

        do_reset("rst2");

        // Training entry 3: 01 -> 10 -> 11 -> 11, then back down.
        lk_pc = 32'h0040_000C;
        #1;
        check("train.lk0", {31'd0, lk_taken}, 32'd0);
        resolve("train1", 32'h0040_000C, 32'h0, 32'h0, 3'b110, 1'b0, 1'b0, 1'b1);
        check("train1.lk", {31'd0, lk_taken}, 32'd1);
        resolve("train2", 32'h0040_000C, 32'h0, 32'h0, 3'b110, 1'b0, 1'b0, 1'b1);
        resolve("train3", 32'h0040_000C, 32'h0, 32'h0, 3'b110, 1'b0, 1'b0, 1'b1);
        check("train3.lk", {31'd0, lk_taken}, 32'd1);
        check("train3.cnt3", {16'd0, mispred_cnt}, 32'd3);
        resolve("down1", 32'h0040_000C, 32'h0, 32'h0, 3'b111, 1'b1, 1'b0, 1'b0);
        check("down1.lk", {31'd0, lk_taken}, 32'd1);
        resolve("down2", 32'h0040_000C, 32'h0, 32'h0, 3'b111, 1'b1, 1'b0, 1'b0);
        check("down2.lk", {31'd0, lk_taken}, 32'd0);
        idle();

        // Flushed mispredicting request: no result, no training, no count.
        resolve("flush", 32'h0040_000C, 32'h0, 32'h0, 3'b110, 1'b0, 1'b1, 1'b1);
        check("flush.lk", {31'd0, lk_taken}, 32'd0);
        check("flush.hold_taken", {31'd0, out_taken}, 32'd0);
        check("flush.hold_mispred", {31'd0, out_mispred}, 32'd1);

        // Same-cycle lookup and update at index 3 (entry 01).
        rs_valid = 1'b1;
        rs_pc    = 32'h0040_000C;
        rs_func  = 3'b110;
        rs_pred  = 1'b1;
        flush    = 1'b0;
        #1;
        check("rbw.before", {31'd0, lk_taken}, 32'd0);
        @(posedge clk);
        #1;
        check("rbw.after", {31'd0, lk_taken}, 32'd1);
        check("rbw.valid", {31'd0, out_valid}, 32'd1);

        // Back-to-back requests, then hold while idle.
        resolve("b2b1", 32'h0040_0010, 32'h5, 32'h5, 3'b000, 1'b0, 1'b0, 1'b1);
        resolve("b2b2", 32'h0040_0010, 32'h5, 32'h6, 3'b000, 1'b1, 1'b0, 1'b0);
        idle();
        check("b2b.idle_valid", {31'd0, out_valid}, 32'd0);
        check("b2b.hold_taken", {31'd0, out_taken}, 32'd0);
        check("b2b.hold_mispred", {31'd0, out_mispred}, 32'd1);

        // Saturate the mispredict counter.
        do_reset("rst3");
        rs_valid = 1'b1;
        rs_pc    = 32'h0040_000C;
        rs_func  = 3'b110;
        rs_pred  = 1'b0;
        flush    = 1'b0;
        repeat (65535) @(posedge clk);
        #1;
        check("sat.full", {16'd0, mispred_cnt}, 32'h0000_FFFF);
        @(posedge clk);
        #1;
        check("sat.stay", {16'd0, mispred_cnt}, 32'h0000_FFFF);
        check("sat.valid", {31'd0, out_valid}, 32'd1);

        // Reset mid-stream drops the in-flight result immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.valid", {31'd0, out_valid}, 32'd0);
        check("midrst.cnt", {16'd0, mispred_cnt}, 32'd0);
        check("midrst.lk", {31'd0, lk_taken}, 32'd0);
        rs_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 16'h0000;
        resolve("resume", 32'h0040_000C, 32'h0, 32'h0, 3'b110, 1'b0, 1'b0, 1'b1);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
